// File: rtl/smg_display_arbiter_if.sv
// Display arbitration bus: per-source requests/values in, owner and clamped value out.
interface smg_display_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0][7:0] req_data;   // source i at bits [8i+7:8i]
  logic [N_REQ-1:0]      grant;
  logic [7:0]            disp_data;
  logic                  disp_active;
  logic                  sat_flag;

  // sources drive requests and values, observe the grant and display value
  modport master (
    output req, req_data,
    input  grant, disp_data, disp_active, sat_flag
  );

  // arbiter samples requests and owns the display outputs
  modport slave (
    input  req, req_data,
    output grant, disp_data, disp_active, sat_flag
  );
endinterface

// File: rtl/smg_display_arbiter.sv
// Round-robin owner of the two-digit display with a minimum dwell per grant.
// The shown value is clamped to 0..99; sat_flag marks a clamped value.
module smg_display_arbiter #(
  parameter int         N_REQ       = 4,
  parameter int         HOLD_CYCLES = 50000000,
  parameter int         CNT_W       = 26,
  parameter logic [7:0] IDLE_VALUE  = 8'd0
) (
  input logic                   CLK,
  input logic                   RST,
  smg_display_arbiter_if.slave  bus
);
  localparam int               IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       disp_q, disp_d;
  logic             act_q, act_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;   // current/most recent owner

  logic [N_REQ-1:0][7:0] clamped;
  logic [N_REQ-1:0]      over;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      win;
  logic                  win_vld;

  // per-source clamp to the displayable range
  for (genvar i = 0; i < N_REQ; i++) begin : g_clamp
    assign over[i]    = bus.req_data[i] > 8'd99;
    assign clamped[i] = over[i] ? 8'd99 : bus.req_data[i];
  end

  // round-robin search from last_q+1; walking backwards lets the nearest
  // requester overwrite farther ones, and last_q itself is checked last
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    idx     = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_q) + k) % N_REQ);
      if (bus.req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // next state: dwell countdown, (re)arbitration on expiry, or drop to idle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    disp_d  = disp_q;
    act_d   = act_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (state_q == HOLD && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      // owner withdrawn: keep showing the last captured value until expiry
      if (bus.req[last_q]) begin
        disp_d = clamped[last_q];
        sat_d  = over[last_q];
      end
    end else if (win_vld) begin
      // new grant (or owner re-granted) loads the value at the same edge
      state_d      = HOLD;
      grant_d      = '0;
      grant_d[win] = 1'b1;
      last_d       = win;
      cnt_d        = RELOAD;
      act_d        = 1'b1;
      disp_d       = clamped[win];
      sat_d        = over[win];
    end else begin
      state_d = IDLE;
      grant_d = '0;
      act_d   = 1'b0;
      disp_d  = IDLE_VALUE;
      sat_d   = 1'b0;
    end
  end

  // state register; reset points last owner at N_REQ-1 so index 0 wins first
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      disp_q  <= IDLE_VALUE;
      act_q   <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      disp_q  <= disp_d;
      act_q   <= act_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.disp_data   = disp_q;
  assign bus.disp_active = act_q;
  assign bus.sat_flag    = sat_q;
endmodule

// File: doc/smg_display_arbiter.md
Name: smg_display_arbiter

Overview:
Shares the two-digit seven-segment display path between up to N_REQ independent value sources (key status, counters, timers). Sources are served round-robin with a guaranteed minimum dwell time per source, so the digits never flicker between sources. The selected value is clamped to the displayable range 0..99. disp_data drives the 8-bit data input of the decimal split / encode / scan chain, replacing the single hard-wired value register.

Parameters:
N_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 50000000, minimum dwell per grant in CLK cycles (1 s at 50 MHz); must be >= 2
CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > HOLD_CYCLES
IDLE_VALUE, 8'd0, value shown when no source is granted

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST  input  1  synchronous reset, active-high
req  input  N_REQ  per-source display request, level-sensitive
req_data  input  8*N_REQ  per-source value; source i occupies bits [8i+7:8i]
grant  output  N_REQ  one-hot current owner; all zero when idle
disp_data  output  8  value to the display chain, always 0..99
disp_active  output  1  high while any source holds the grant
sat_flag  output  1  high when the granted raw value exceeds 99 and is being clamped

Behaviour:
Reset and interface:
- One clock; reset is synchronous and active-high.
- Reset (RST high at an edge) sets: state=IDLE, grant=0, disp_data=IDLE_VALUE, disp_active=0, sat_flag=0, dwell counter=0, last_owner=N_REQ-1 (so index 0 wins first).
- All outputs are registered.

State machine (two states, IDLE and HOLD):
- IDLE, no req bit high: stay in IDLE; disp_data=IDLE_VALUE.
- IDLE, any req bit high at an edge: select the winner round-robin.
  - Search order is last_owner+1, last_owner+2, ... wrapping modulo N_REQ; the first requesting index wins.
  - At that same edge: grant=onehot(winner), last_owner=winner, counter=HOLD_CYCLES-1, disp_active=1, state=HOLD.
  - Latency: request to grant is one edge.
- HOLD, counter != 0: decrement the counter.
  - If req[owner] is high, disp_data and sat_flag track req_data[owner] every cycle, with one cycle of latency.
  - If req[owner] has dropped, disp_data freezes at the last captured value (minimum dwell is honoured even after withdrawal).
  - Other requests are ignored until expiry.
- HOLD, counter == 0 (expiry), any req bit high at the edge:
  - Re-arbitrate round-robin from last_owner+1. The current owner counts as a candidate only after all other indices.
  - If a different index wins: switch grant, reload the counter, and load disp_data from the new source at the same edge. There is no blank cycle.
  - If the owner is the only requester: it keeps the grant, the counter reloads, and tracking continues.
- HOLD, counter == 0, no req high: state=IDLE, grant=0, disp_active=0, disp_data=IDLE_VALUE, sat_flag=0.

Arithmetic:
- Clamp rule: disp_data = (raw > 99) ? 99 : raw, where raw is the 8-bit unsigned value. sat_flag = (raw > 99). Both are registered together.

Boundary conditions:
- Simultaneous requests from all sources: strict rotation 0,1,2,3,0,... with one dwell each.
- A req pulse shorter than one cycle between edges is not seen. A req that is high at the IDLE sampling edge is granted even if it drops on the next cycle.
- req_data changes on a non-owner have no effect.
- Reset mid-HOLD overrides everything at that edge. The next arbitration starts from index 0.
- Counter never underflows; the expiry decision is taken exactly at the edge where the counter is 0.

Test Plan:
(All scenarios use HOLD_CYCLES=8, N_REQ=4.)
1. Hold RST high for 3 cycles with req=4'b1111 -> grant=0, disp_data=0, disp_active=0, sat_flag=0 throughout. Release RST -> one edge later grant=4'b0001.
2. req=4'b0100, data2=8'd37 -> grant=4'b0100 one edge later, disp_data=37. Change data2 to 42 mid-dwell -> disp_data=42 one cycle later.
3. req=4'b0011 continuously, data0=11, data1=22 -> disp_data alternates 11/22, each for exactly 8 cycles; grant alternates 0001/0010 with no idle gap.
4. req0 pulses high for 2 cycles with data0=5, then stays low -> disp_data=5 and grant=0001 for exactly 8 cycles, then IDLE, disp_data=0, disp_active=0.
5. req=4'b1000, data3=8'd150 -> disp_data=99, sat_flag=1. Set data3=8'd99 -> sat_flag=0, disp_data=99. Set data3=8'd100 -> sat_flag=1.
6. req=4'b1111 with all four sources; assert RST during source 2's dwell -> outputs reset at that edge. After release, grant order restarts 0,1,2,3.
